debounce_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_chan.sv | 137 +++++++++++++
 rtl/debounce_multi.sv | 43 ++++
 tb/tb_debounce_multi.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default timing for the multi-channel key debouncer.
// The auto-repeat option is selected at build time with DEBOUNCE_REPEAT_EN.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PCHK = 2'd1,
      HELD = 2'd2,
      RCHK = 2'd3
   } chan_state_e;

   localparam int DEF_N          = 5;
   localparam int DEF_STABLE_CNT = 20;
   localparam int DEF_CNT_W      = 16;
   localparam int DEF_ACTIVE_LOW = 1;
   localparam int DEF_REPEAT_DLY = 100;
   localparam int DEF_REPEAT_PER = 25;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchroniser, qualification FSM and counter.
// With DEBOUNCE_REPEAT_EN defined, a held key emits periodic repeat pulses.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int STABLE_CNT = DEF_STABLE_CNT,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int REPEAT_DLY = DEF_REPEAT_DLY,
   parameter int REPEAT_PER = DEF_REPEAT_PER
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   output logic state_o,
   output logic pulse_o,
   output logic release_o
);

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

   logic             sync1_q;
   logic             sync2_q;
   chan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cntInc;
   logic             pulse_q, pulse_d;
   logic             rel_q, rel_d;

`ifdef DEBOUNCE_REPEAT_EN
   localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(REPEAT_DLY - 1);
   localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(REPEAT_PER - 1);

   logic rpt_q, rpt_d;

   // Remembers whether the first (long) repeat delay has already elapsed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_q <= 1'b0;
      end else begin
         rpt_q <= rpt_d;
      end
   end
`else
   localparam int unusedRptCfg = REPEAT_DLY + REPEAT_PER;
`endif

   assign cntInc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   // Input is already normalised to 1 = pressed, so zero is the idle level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         rel_q   <= rel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      rel_d   = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      rpt_d   = rpt_q;
`endif
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = PCHK;
               cnt_d   = CNT_ONE;
            end
         end
         PCHK: begin
            if (!sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = HELD;
               pulse_d = 1'b1;
               cnt_d   = '0;
`ifdef DEBOUNCE_REPEAT_EN
               rpt_d   = 1'b0;
`endif
            end else begin
               cnt_d = cntInc;
            end
         end
         HELD: begin
            if (!sync2_q) begin
               state_d = RCHK;
               cnt_d   = CNT_ONE;
            end
`ifdef DEBOUNCE_REPEAT_EN
            else if (cnt_q == (rpt_q ? RPT_PER_LAST : RPT_DLY_LAST)) begin
               pulse_d = 1'b1;
               cnt_d   = '0;
               rpt_d   = 1'b1;
            end else begin
               cnt_d = cntInc;
            end
`endif
         end
         RCHK: begin
            if (sync2_q) begin
               state_d = HELD;
               cnt_d   = '0;
`ifdef DEBOUNCE_REPEAT_EN
               rpt_d   = 1'b0;
`endif
            end else if (cnt_q == STABLE_LAST) begin
               state_d = IDLE;
               rel_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cntInc;
            end
         end
      endcase
   end

   assign state_o   = (state_q == HELD) || (state_q == RCHK);
   assign pulse_o   = pulse_q;
   assign release_o = rel_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel key debouncer: polarity handling and per-channel instance array.
// Define DEBOUNCE_REPEAT_EN to build the auto-repeat variant.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int STABLE_CNT = DEF_STABLE_CNT,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int ACTIVE_LOW = DEF_ACTIVE_LOW,
   parameter int REPEAT_DLY = DEF_REPEAT_DLY,
   parameter int REPEAT_PER = DEF_REPEAT_PER
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] key,
   output logic [N-1:0] key_state,
   output logic [N-1:0] key_pulse,
   output logic [N-1:0] key_release
);

   logic [N-1:0] keyNorm;

   // Inverting ahead of the synchroniser is equivalent to inverting after it,
   // and lets every channel reset its sync flops to 0 as the idle level
   assign keyNorm = (ACTIVE_LOW != 0) ? ~key : key;

   for (genvar i = 0; i < N; i++) begin : gChan
      debounce_chan #(
         .STABLE_CNT(STABLE_CNT),
         .CNT_W     (CNT_W),
         .REPEAT_DLY(REPEAT_DLY),
         .REPEAT_PER(REPEAT_PER)
      ) uChan (
         .clk      (clk),
         .rst_n    (rst_n),
         .key_i    (keyNorm[i]),
         .state_o  (key_state[i]),
         .pulse_o  (key_pulse[i]),
         .release_o(key_release[i])
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi (N=5, STABLE_CNT=4, active-low keys).
// Build with DEBOUNCE_REPEAT_EN defined to exercise the auto-repeat variant.
module tb_debounce_multi;

   localparam int N      = 5;
   localparam int STABLE = 4;
   localparam int LAT    = STABLE + 2;

   typedef struct {
      int           cyc;
      logic [N-1:0] pulse;
      logic [N-1:0] rel;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] key = 5'b11111;
   logic [N-1:0] key_state;
   logic [N-1:0] key_pulse;
   logic [N-1:0] key_release;

   int  tests = 0;
   int  errors = 0;
   int  cyc = 0;
   int  edgeCyc = 0;
   ev_t sbQ[$];
   ev_t monEv;

   debounce_multi #(
      .N         (N),
      .STABLE_CNT(STABLE),
      .CNT_W     (16),
      .ACTIVE_LOW(1),
      .REPEAT_DLY(10),
      .REPEAT_PER(5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key),
      .key_state  (key_state),
      .key_pulse  (key_pulse),
      .key_release(key_release)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every pulse or release strobe must match the next scoreboard entry exactly
   always @(negedge clk) begin
      if (key_pulse !== '0 || key_release !== '0) begin
         tests++;
         if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_strobe cyc=%0d got pulse=%b release=%b required none",
                     cyc, key_pulse, key_release);
         end else begin
            monEv = sbQ.pop_front();
            if (monEv.cyc != cyc || monEv.pulse !== key_pulse || monEv.rel !== key_release) begin
               errors++;
               $display("[TB] FAIL strobe got cyc=%0d pulse=%b release=%b required cyc=%0d pulse=%b release=%b",
                        cyc, key_pulse, key_release, monEv.cyc, monEv.pulse, monEv.rel);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [N-1:0] k);
      @(negedge clk);
      key = k;
      edgeCyc = cyc;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pushEvent(input int at, input logic [N-1:0] p, input logic [N-1:0] r);
      ev_t e;
      e.cyc = at;
      e.pulse = p;
      e.rel = r;
      sbQ.push_back(e);
   endtask

   task automatic test_reset();
      waitCycles(3);
      tests++;
      if ({key_state, key_pulse, key_release} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_state got %b/%b/%b required all zero", key_state, key_pulse, key_release);
      end
      rst_n = 1'b1;
      applyStimulus(5'b11110);
      pushEvent(edgeCyc + LAT, 5'b00001, 5'b00000);
      waitCycles(8);
      tests++;
      if (key_state !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL pre_reset_state got %b required 00001", key_state);
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      tests++;
      if ({key_state, key_pulse, key_release} !== '0) begin
         errors++;
         $display("[TB] FAIL async_reset got %b/%b/%b required all zero", key_state, key_pulse, key_release);
      end
      waitCycles(2);
      rst_n = 1'b1;
      pushEvent(cyc + LAT, 5'b00001, 5'b00000);
      waitCycles(8);
      tests++;
      if (key_state !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL requalify_state got %b required 00001", key_state);
      end
      applyStimulus(5'b11111);
      pushEvent(edgeCyc + LAT, 5'b00000, 5'b00001);
      waitCycles(50);
      tests++;
      if (key_state !== '0 || sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL reset_idle got state=%b pending=%0d required 00000/0", key_state, sbQ.size());
      end
   endtask

   task automatic test_bouncy_press();
      for (int t = 0; t < 5; t++) begin
         applyStimulus((t % 2 == 0) ? 5'b01111 : 5'b11111);
         if (t < 4) waitCycles(2);
      end
      pushEvent(edgeCyc + LAT, 5'b10000, 5'b00000);
      waitCycles(LAT - 1);
      tests++;
      if (key_state[4] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL press_early got %b required 0", key_state[4]);
      end
      waitCycles(1);
      tests++;
      if (key_state[4] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL press_latency got %b required 1", key_state[4]);
      end
      waitCycles(10);
      tests++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL press_missing got %0d pending required 0", sbQ.size());
      end
   endtask

   task automatic test_bouncy_release();
      for (int t = 0; t < 5; t++) begin
         applyStimulus((t % 2 == 0) ? 5'b11111 : 5'b01111);
         if (t < 4) waitCycles(2);
      end
      pushEvent(edgeCyc + LAT, 5'b00000, 5'b10000);
      waitCycles(LAT - 1);
      tests++;
      if (key_state[4] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL release_early got %b required 1", key_state[4]);
      end
      waitCycles(1);
      tests++;
      if (key_state[4] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL release_latency got %b required 0", key_state[4]);
      end
      waitCycles(10);
      tests++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL release_missing got %0d pending required 0", sbQ.size());
      end
   endtask

   task automatic test_glitch();
      applyStimulus(5'b11110);
      waitCycles(2);
      applyStimulus(5'b11111);
      waitCycles(15);
      tests++;
      if (key_state !== '0 || sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL glitch got state=%b pending=%0d required 00000/0", key_state, sbQ.size());
      end
   endtask

   task automatic test_simultaneous();
      applyStimulus(5'b10101);
      pushEvent(edgeCyc + LAT, 5'b01010, 5'b00000);
      waitCycles(LAT);
      tests++;
      if (key_state !== 5'b01010) begin
         errors++;
         $display("[TB] FAIL simul_state got %b required 01010", key_state);
      end
      applyStimulus(5'b11111);
      pushEvent(edgeCyc + LAT, 5'b00000, 5'b01010);
      waitCycles(10);
      tests++;
      if (key_state !== '0 || sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL simul_release got state=%b pending=%0d required 00000/0", key_state, sbQ.size());
      end
   endtask

   task automatic test_hold();
      int q;
      applyStimulus(5'b11011);
      q = edgeCyc + LAT;
      pushEvent(q, 5'b00100, 5'b00000);
`ifdef DEBOUNCE_REPEAT_EN
      for (int k = 10; k <= 35; k += 5) pushEvent(q + k, 5'b00100, 5'b00000);
`endif
      waitCycles(q + 35 - cyc);
      tests++;
      if (key_state !== 5'b00100) begin
         errors++;
         $display("[TB] FAIL hold_state got %b required 00100", key_state);
      end
      applyStimulus(5'b11111);
      pushEvent(edgeCyc + LAT, 5'b00000, 5'b00100);
      waitCycles(20);
      tests++;
      if (key_state !== '0 || sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL hold_done got state=%b pending=%0d required 00000/0", key_state, sbQ.size());
      end
   endtask

   initial begin
      test_reset();
      test_bouncy_press();
      test_bouncy_release();
      test_glitch();
      test_simultaneous();
      test_hold();
      waitCycles(2);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
